// File: rtl/test_seq_ctrl.sv
// ============================================================================
// test_seq_ctrl : register-programmed step scheduler for the on-chip test
//                 structures (enable mask + PWM divider per step, guarded gaps)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module test_seq_ctrl #(
  parameter int DEPTH   = 8,
  parameter int GUARD   = 4,
  parameter int DWELL_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic [3:0]  en_o,
  output logic [3:0]  div_sel_o,
  output logic        busy_o,
  output logic [3:0]  step_o,
  output logic        done_irq_o
);

  localparam int             c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]     c_DEPTH    = 5'(DEPTH);
  // The LOAD cycle also shows en_o=0, so GAP itself lasts GUARD-1 cycles.
  localparam int             c_GAP_INIT = (GUARD > 1) ? GUARD - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           step_q, step_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           en_q, en_d;
  logic [3:0]           div_q, div_d;
  logic                 done_q, done_d;
  logic                 irq_q, irq_d;
  logic                 loop_q, loop_d;
  logic [4:0]           nsteps_q, nsteps_d;

  logic [3:0]           tbl_en_q    [DEPTH];
  logic [3:0]           tbl_div_q   [DEPTH];
  logic [DWELL_W-1:0]   tbl_dwell_q [DEPTH];

  logic                 w_ctrl_wr;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_nsteps_wr;
  logic [4:0]           w_tidx;
  logic                 w_tbl_hit;
  logic                 w_busy;
  logic                 w_last;
  logic [c_IDX_W-1:0]   w_cur_idx;
  logic                 w_unused;

  assign w_ctrl_wr   = cfg_we && (cfg_addr == 5'd0);
  assign w_stop      = w_ctrl_wr && cfg_wdata[1];
  assign w_start     = w_ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign w_nsteps_wr = cfg_we && (cfg_addr == 5'd1);
  assign w_tidx      = cfg_addr - 5'd8;
  assign w_tbl_hit   = (cfg_addr >= 5'd8) && (w_tidx < c_DEPTH);
  assign w_busy      = (state_q == S_LOAD) || (state_q == S_DWELL) || (state_q == S_GAP);
  assign w_last      = (({1'b0, step_q} + 5'd1) >= nsteps_q);
  assign w_cur_idx   = step_q[c_IDX_W-1:0];
  assign w_unused    = ^cfg_wdata;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    div_d    = div_q;
    done_d   = done_q;
    irq_d    = 1'b0;
    loop_d   = loop_q;
    nsteps_d = nsteps_q;

    if (w_ctrl_wr) loop_d = cfg_wdata[2];
    if (w_nsteps_wr) nsteps_d = (cfg_wdata[4:0] > c_DEPTH) ? c_DEPTH : cfg_wdata[4:0];

    if (w_stop) begin
      state_d = S_IDLE;
      en_d    = 4'd0;
      done_d  = 1'b0;
      step_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (w_start && (nsteps_q != 5'd0)) begin
            state_d = S_LOAD;
            step_d  = 4'd0;
            done_d  = 1'b0;
          end
        end
        S_LOAD: begin
          en_d    = tbl_en_q[w_cur_idx];
          div_d   = tbl_div_q[w_cur_idx];
          cnt_d   = tbl_dwell_q[w_cur_idx];
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (cnt_q == '0) begin
            en_d = 4'd0;
            if (w_last && !loop_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end else begin
              step_d  = w_last ? 4'd0 : step_q + 4'd1;
              cnt_d   = DWELL_W'(c_GAP_INIT);
              state_d = (GUARD > 1) ? S_GAP : S_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_d = S_LOAD;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      step_q   <= 4'd0;
      cnt_q    <= '0;
      en_q     <= 4'd0;
      div_q    <= 4'd0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      loop_q   <= 1'b0;
      nsteps_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      div_q    <= div_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      loop_q   <= loop_d;
      nsteps_q <= nsteps_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_en_q[i]    <= 4'd0;
        tbl_div_q[i]   <= 4'd0;
        tbl_dwell_q[i] <= '0;
      end
    end else if (cfg_we && w_tbl_hit) begin
      tbl_div_q[w_tidx[c_IDX_W-1:0]]   <= cfg_wdata[3:0];
      tbl_en_q[w_tidx[c_IDX_W-1:0]]    <= cfg_wdata[7:4];
      tbl_dwell_q[w_tidx[c_IDX_W-1:0]] <= cfg_wdata[16 +: DWELL_W];
    end
  end

  always_comb begin
    cfg_rdata = 32'd0;
    if (cfg_addr == 5'd0) begin
      cfg_rdata[0]   = w_busy;
      cfg_rdata[1]   = done_q;
      cfg_rdata[2]   = loop_q;
      cfg_rdata[7:4] = step_q;
    end else if (cfg_addr == 5'd1) begin
      cfg_rdata[4:0] = nsteps_q;
    end else if (w_tbl_hit) begin
      cfg_rdata[3:0]          = tbl_div_q[w_tidx[c_IDX_W-1:0]];
      cfg_rdata[7:4]          = tbl_en_q[w_tidx[c_IDX_W-1:0]];
      cfg_rdata[16 +: DWELL_W] = tbl_dwell_q[w_tidx[c_IDX_W-1:0]];
    end
  end

  assign en_o       = en_q;
  assign div_sel_o  = div_q;
  assign busy_o     = w_busy;
  assign step_o     = step_q;
  assign done_irq_o = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_test_seq_ctrl.sv
// ============================================================================
// tb_test_seq_ctrl : bench for test_seq_ctrl (register vectors, directed
//                    corner sequences, randomized runs vs. timeline model)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_test_seq_ctrl;

  localparam int DEPTH   = 8;
  localparam int GUARD   = 4;
  localparam int DWELL_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  en, div, step;
  logic        busy, irq;

  always #5 clk = ~clk;

  test_seq_ctrl #(.DEPTH(DEPTH), .GUARD(GUARD), .DWELL_W(DWELL_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cfg_we     (we),
    .cfg_addr   (addr),
    .cfg_wdata  (wdata),
    .cfg_rdata  (rdata),
    .en_o       (en),
    .div_sel_o  (div),
    .busy_o     (busy),
    .step_o     (step),
    .done_irq_o (irq)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] div;
    logic [3:0] step;
    logic       busy;
    logic       irq;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the programmed table and the expected per-cycle output timeline.
  int         m_en  [DEPTH];
  int         m_div [DEPTH];
  int         m_dw  [DEPTH];
  int         m_n;
  logic [3:0] cur_div;
  exp_t       q [$];
  int         final_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  function automatic exp_t mk(input int e, input int d, input int s, input bit b, input bit i);
    exp_t r;
    r.en = 4'(e); r.div = 4'(d); r.step = 4'(s); r.busy = b; r.irq = i;
    return r;
  endfunction

  task automatic prog_step(input int k, input int e, input int dv, input int dw);
    m_en[k] = e; m_div[k] = dv; m_dw[k] = dw;
    wr(5'(8 + k), (32'(dw) << 16) | (32'(e) << 4) | 32'(dv));
  endtask

  // Timeline: LOAD, then per step dwell+1 active cycles, GUARD idle cycles
  // between steps, then DONE with one irq cycle.
  task automatic build(input int passes);
    int lst [$];
    int k;
    q.delete();
    final_start = -1;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < m_n; s++) lst.push_back(s);
    q.push_back(mk(0, cur_div, 0, 1, 0));
    for (int j = 0; j < lst.size(); j++) begin
      k = lst[j];
      if (passes > 1 && j == (passes - 1) * m_n) final_start = q.size() - GUARD;
      for (int c = 0; c <= m_dw[k]; c++) q.push_back(mk(m_en[k], m_div[k], k, 1, 0));
      if (j < lst.size() - 1)
        for (int g = 0; g < GUARD; g++) q.push_back(mk(0, m_div[k], lst[j + 1], 1, 0));
    end
    k = lst[lst.size() - 1];
    q.push_back(mk(0, m_div[k], k, 0, 1));
    q.push_back(mk(0, m_div[k], k, 0, 0));
    cur_div = 4'(m_div[k]);
  endtask

  task automatic run(input string name, input int wr_at, input logic [4:0] wa, input logic [31:0] wd);
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), {18'd0, en, div, step, busy, irq}, {18'd0, q[i]});
      if (i == wr_at) begin
        we = 1'b1; addr = wa; wdata = wd;
      end
      @(negedge clk);
      we = 1'b0;
    end
  endtask

  task automatic chk_outs_zero(input string name);
    check(name, {18'd0, en, div, step, busy, irq}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [12];
    int   passes;
    vecs[0]  = '{5'd1,  32'd20,        32'd8};
    vecs[1]  = '{5'd1,  32'd3,         32'd3};
    vecs[2]  = '{5'd1,  32'd0,         32'd0};
    vecs[3]  = '{5'd1,  32'd8,         32'd8};
    vecs[4]  = '{5'd1,  32'd31,        32'd8};
    vecs[5]  = '{5'd8,  32'hFFFF_FFFF, 32'hFFFF_00FF};
    vecs[6]  = '{5'd15, 32'h1234_5678, 32'h1234_0078};
    vecs[7]  = '{5'd16, 32'hFFFF_FFFF, 32'd0};
    vecs[8]  = '{5'd2,  32'hFFFF_FFFF, 32'd0};
    vecs[9]  = '{5'd31, 32'd1,         32'd0};
    vecs[10] = '{5'd0,  32'd4,         32'd4};
    vecs[11] = '{5'd0,  32'd0,         32'd0};

    rst = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outs");
    rd_check("reset_ctrl", 5'd0, 32'd0);
    rd_check("reset_nsteps", 5'd1, 32'd0);
    rd_check("reset_step0", 5'd8, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rexp);
    end
    cur_div = 4'd0;

    // Basic two-step run.
    prog_step(0, 1, 3, 5);
    prog_step(1, 8, 7, 0);
    m_n = 2; wr(5'd1, 32'd2);
    build(1);
    wr(5'd0, 32'd1);
    run("basic", -1, 5'd0, 32'd0);
    rd_check("basic_ctrl_done", 5'd0, 32'h12);

    // Three passes with loop, loop cleared during the final pass.
    build(3);
    wr(5'd0, 32'd5);
    run("loop", final_start, 5'd0, 32'd0);
    rd_check("loop_ctrl_done", 5'd0, 32'h12);

    // Stop during step0 dwell.
    wr(5'd0, 32'd1);
    @(negedge clk);
    check("stop_pre_en", {28'd0, en}, 32'd1);
    wr(5'd0, 32'd6);
    check("stop_outs", {29'd0, en == 4'd0, busy, irq}, 32'h4);
    rd_check("stop_ctrl", 5'd0, 32'h4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("stop_quiet%0d", i), {30'd0, busy, irq}, 32'd0);
    end
    wr(5'd0, 32'd0);
    cur_div = 4'd3;

    // Start with NSTEPS=0 is ignored; saturation readback.
    wr(5'd1, 32'd0);
    wr(5'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nsteps0_idle%0d", i), {27'd0, busy, en}, 32'd0);
      @(negedge clk);
    end
    wr(5'd1, 32'd20);
    rd_check("nsteps_sat", 5'd1, 32'd8);

    // Rewrite STEP1 dwell during step0 dwell.
    m_n = 2; wr(5'd1, 32'd2);
    m_dw[1] = 3;
    build(1);
    wr(5'd0, 32'd1);
    run("rewrite", 2, 5'd9, (32'd3 << 16) | 32'h87);

    // Start and stop together.
    wr(5'd0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("startstop%0d", i), {27'd0, busy, en}, 32'd0);
      @(negedge clk);
    end

    // Reset during GAP.
    prog_step(1, 8, 7, 0);
    wr(5'd0, 32'd1);
    repeat (7) @(negedge clk);
    check("gap_pre", {27'd0, busy, en}, 32'h10);
    rst = 1'b1;
    @(negedge clk);
    chk_outs_zero("gap_rst_outs");
    rst = 1'b0;
    rd_check("gap_rst_step0", 5'd8, 32'd0);
    rd_check("gap_rst_step1", 5'd9, 32'd0);
    rd_check("gap_rst_nsteps", 5'd1, 32'd0);
    rd_check("gap_rst_ctrl", 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs_zero($sformatf("gap_rst_quiet%0d", i));
    end

    // Post-reset run behaves as from power-up.
    cur_div = 4'd0;
    prog_step(0, 1, 3, 5);
    prog_step(1, 8, 7, 0);
    m_n = 2; wr(5'd1, 32'd2);
    build(1);
    wr(5'd0, 32'd1);
    run("post_rst", -1, 5'd0, 32'd0);

    // Randomized programs; single-pass runs also get an ignored start mid-run.
    for (int it = 0; it < 10; it++) begin
      m_n = $urandom_range(1, DEPTH);
      for (int k = 0; k < m_n; k++)
        prog_step(k, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 6));
      wr(5'd1, 32'(m_n));
      passes = $urandom_range(1, 2);
      build(passes);
      if (passes > 1) begin
        wr(5'd0, 32'd5);
        run($sformatf("rnd%0d", it), final_start, 5'd0, 32'd0);
      end else begin
        wr(5'd0, 32'd1);
        run($sformatf("rnd%0d", it), $urandom_range(0, q.size() - 3), 5'd0, 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
